// File: rtl/fsb_axis_pkg.sv
// ---------------------------------------------------------------------------
// fsb_axis_pkg
// Shared types and constants for the FSB -> AXI-Stream transmit arbiter.
//   FSB_PKT_W   : width of one FSB packet (one 128-bit beat carries one packet)
//   AXIS_W      : AXI-Stream data width toward the 128->512 width converter
//   TKEEP_DATA  : keep mask for a beat carrying an 80-bit FSB packet
//   TKEEP_PAD   : keep mask for a filler beat that completes a short burst
//   arb_state_e : arbiter FSM states
// ---------------------------------------------------------------------------
package fsb_axis_pkg;

  localparam int FSB_PKT_W = 80;
  localparam int AXIS_W    = 128;

  localparam logic [15:0] TKEEP_DATA = 16'h03FF;
  localparam logic [15:0] TKEEP_PAD  = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_PAD   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fsb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fsb_rr_arbiter
// Combinational round-robin picker. Starting one past the previous winner and
// wrapping around, returns the first requester whose request is high.
// Ports:
//   req         : per-requester request vector
//   last_grant  : index of the previous winner
//   grant_valid : high when at least one request is present
//   grant_idx   : index of the chosen requester (0 when none)
// ---------------------------------------------------------------------------
module fsb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  // Walk the requesters in priority order (last_grant+1 first, last_grant
  // last) and latch the first hit; the found flag keeps later hits out.
  always_comb begin
    int cand;
    cand        = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last_grant) + off) % NUM_REQ;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fsb_axis_tx_arbiter.sv
// ---------------------------------------------------------------------------
// fsb_axis_tx_arbiter
// Arbitrates NUM_REQ FSB requesters onto one 128-bit AXI-Stream master. Each
// grant moves a burst of BURST_BEATS beats (one 512-bit FIFO word after the
// width converter) and costs one downstream credit. A burst that stalls for
// PAD_TIMEOUT cycles is completed with zero-keep filler beats so the
// downstream word always closes with tlast.
// Ports:
//   clk_i, resetn_i        : clock, asynchronous active-low reset
//   req_v_i / req_data_i   : per-requester packet valid / 80-bit packets
//   req_r_o                : per-requester ready (only the granted one)
//   m_tvalid_o .. m_tlast_o: registered AXI-Stream master outputs
//   m_tready_i             : AXI-Stream ready
//   credit_return_i        : one pulse per 512-bit word drained downstream
//   credits_o              : current credit count
//   busy_o                 : high while a burst (or its padding) is active
//   stats_o                : per-requester saturating accepted-beat counters,
//                            present only when FSB_ARB_STATS_EN is defined
// ---------------------------------------------------------------------------
module fsb_axis_tx_arbiter
  import fsb_axis_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int BURST_BEATS = 4,
  parameter int CREDITS     = 512,
  parameter int PAD_TIMEOUT = 16
) (
  input  logic                           clk_i,
  input  logic                           resetn_i,
  input  logic [NUM_REQ-1:0]             req_v_i,
  input  logic [NUM_REQ*FSB_PKT_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]             req_r_o,
  output logic                           m_tvalid_o,
  output logic [AXIS_W-1:0]              m_tdata_o,
  output logic [15:0]                    m_tkeep_o,
  output logic                           m_tlast_o,
  input  logic                           m_tready_i,
  input  logic                           credit_return_i,
  output logic [$clog2(CREDITS+1)-1:0]   credits_o,
  output logic                           busy_o
`ifdef FSB_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]          stats_o
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CW    = $clog2(CREDITS + 1);
  localparam int BW    = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int TW    = $clog2(PAD_TIMEOUT + 1);

  arb_state_e         state;
  logic [CW-1:0]      credits;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   grant_q;
  logic [BW-1:0]      beat_cnt;
  logic [TW-1:0]      timeout;

  logic               arb_valid;
  logic [IDX_W-1:0]   arb_idx;
  logic               out_free;
  logic               grant_fire;
  logic               beat_acc;
  logic               beat_last;
  logic [FSB_PKT_W-1:0] grant_pkt;

  fsb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req         (req_v_i),
    .last_grant  (last_grant),
    .grant_valid (arb_valid),
    .grant_idx   (arb_idx)
  );

  // The output register can take a new beat when it is empty or being drained
  // this cycle; both data and pad beats are gated by this.
  assign out_free   = !m_tvalid_o || m_tready_i;
  assign grant_fire = (state == ST_IDLE) && arb_valid && (credits != '0);
  assign beat_acc   = (state == ST_BURST) && out_free && req_v_i[grant_q];
  assign beat_last  = (beat_cnt == BW'(BURST_BEATS - 1));
  assign grant_pkt  = req_data_i[grant_q*FSB_PKT_W +: FSB_PKT_W];

  assign credits_o  = credits;
  assign busy_o     = (state != ST_IDLE);

  // Only the granted requester sees ready, and only while a beat can land in
  // the output register; everyone else is held off.
  always_comb begin
    req_r_o = '0;
    if (state == ST_BURST && out_free) begin
      req_r_o[grant_q] = 1'b1;
    end
  end

  // Main FSM: credit accounting, grant capture, beat counting, stall timeout
  // and the registered AXI-Stream output stage all live here. A grant and a
  // credit return in the same cycle cancel out; returns beyond CREDITS are
  // dropped.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state      <= ST_IDLE;
      credits    <= CW'(CREDITS);
      last_grant <= IDX_W'(NUM_REQ - 1);
      grant_q    <= '0;
      beat_cnt   <= '0;
      timeout    <= '0;
      m_tvalid_o <= 1'b0;
      m_tdata_o  <= '0;
      m_tkeep_o  <= '0;
      m_tlast_o  <= 1'b0;
    end else begin
      if (grant_fire && !credit_return_i) begin
        credits <= credits - CW'(1);
      end else if (!grant_fire && credit_return_i && credits != CW'(CREDITS)) begin
        credits <= credits + CW'(1);
      end

      if (m_tvalid_o && m_tready_i) begin
        m_tvalid_o <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (grant_fire) begin
            state    <= ST_BURST;
            grant_q  <= arb_idx;
            beat_cnt <= '0;
            timeout  <= '0;
          end
        end

        ST_BURST: begin
          if (beat_acc) begin
            m_tvalid_o <= 1'b1;
            m_tdata_o  <= {{(AXIS_W - FSB_PKT_W){1'b0}}, grant_pkt};
            m_tkeep_o  <= TKEEP_DATA;
            m_tlast_o  <= beat_last;
            timeout    <= '0;
            if (beat_last) begin
              state      <= ST_IDLE;
              last_grant <= grant_q;
              beat_cnt   <= '0;
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end else if (timeout == TW'(PAD_TIMEOUT - 1)) begin
            state   <= ST_PAD;
            timeout <= '0;
          end else begin
            timeout <= timeout + TW'(1);
          end
        end

        ST_PAD: begin
          if (out_free) begin
            m_tvalid_o <= 1'b1;
            m_tdata_o  <= '0;
            m_tkeep_o  <= TKEEP_PAD;
            m_tlast_o  <= beat_last;
            if (beat_last) begin
              state      <= ST_IDLE;
              last_grant <= grant_q;
              beat_cnt   <= '0;
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FSB_ARB_STATS_EN
  logic [31:0] stat_cnt [NUM_REQ];

  // Per-requester accepted-beat counters; they stick at all-ones rather than
  // wrapping so a saturated value is never mistaken for a small one.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_cnt[i] <= '0;
      end
    end else if (beat_acc && stat_cnt[grant_q] != 32'hFFFF_FFFF) begin
      stat_cnt[grant_q] <= stat_cnt[grant_q] + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    assign stats_o[g*32 +: 32] = stat_cnt[g];
  end
`endif

endmodule

// File: tb/tb_fsb_axis_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fsb_axis_tx_arbiter
// Drives per-requester packet queues and random/directed m_tready patterns
// into fsb_axis_tx_arbiter and compares every presented output beat against
// an expected beat stream built burst-by-burst from the round-robin rule.
// ---------------------------------------------------------------------------
module tb_fsb_axis_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int BB          = 4;
  localparam int CREDITS     = 512;
  localparam int PAD_TIMEOUT = 16;
  localparam int CW          = $clog2(CREDITS + 1);

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } beat_t;

  logic                    clk;
  logic                    resetn;
  logic [NUM_REQ-1:0]      req_v;
  logic [NUM_REQ*80-1:0]   req_data;
  logic [NUM_REQ-1:0]      req_r;
  logic                    m_tvalid;
  logic [127:0]            m_tdata;
  logic [15:0]             m_tkeep;
  logic                    m_tlast;
  logic                    m_tready;
  logic                    credit_return;
  logic [CW-1:0]           credits;
  logic                    busy;
`ifdef FSB_ARB_STATS_EN
  logic [NUM_REQ*32-1:0]   stats;
`endif

  fsb_axis_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .BURST_BEATS (BB),
    .CREDITS     (CREDITS),
    .PAD_TIMEOUT (PAD_TIMEOUT)
  ) dut (
    .clk_i           (clk),
    .resetn_i        (resetn),
    .req_v_i         (req_v),
    .req_data_i      (req_data),
    .req_r_o         (req_r),
    .m_tvalid_o      (m_tvalid),
    .m_tdata_o       (m_tdata),
    .m_tkeep_o       (m_tkeep),
    .m_tlast_o       (m_tlast),
    .m_tready_i      (m_tready),
    .credit_return_i (credit_return),
    .credits_o       (credits),
    .busy_o          (busy)
`ifdef FSB_ARB_STATS_EN
    ,
    .stats_o         (stats)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [79:0] pkt_q [NUM_REQ][$];
  beat_t       exp_q [$];
  int          xfer_cyc [$];
  int          cyc          = 0;
  int          tready_mode  = 0;
  int          low_run      = 0;
  int          model_last   = NUM_REQ - 1;
  int          exp_credits  = CREDITS;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, sample outputs 1 unit
  // later, score any presented beat and retire accepted packets.
  task automatic applyStimulus(input bit ret);
    logic [NUM_REQ-1:0] acc;
    @(negedge clk);
    case (tready_mode)
      0: m_tready = 1'b1;
      1: begin
        if (low_run >= 6) m_tready = 1'b1;
        else              m_tready = ($urandom_range(0, 9) < 7);
        low_run = m_tready ? 0 : low_run + 1;
      end
      default: m_tready = ~m_tready;
    endcase
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pkt_q[i].size() > 0) begin
        req_v[i]              = 1'b1;
        req_data[i*80 +: 80]  = pkt_q[i][0];
      end else begin
        req_v[i]              = 1'b0;
        req_data[i*80 +: 80]  = '0;
      end
    end
    credit_return = ret;
    #1;
    checkOutput("ready_onehot", 128'($countones(req_r) <= 1), 128'd1);
    if (m_tvalid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_beat", 128'd1, 128'd0);
      end else begin
        checkOutput("tdata", m_tdata, exp_q[0].data);
        checkOutput("tkeep", 128'(m_tkeep), 128'(exp_q[0].keep));
        checkOutput("tlast", 128'(m_tlast), 128'(exp_q[0].last));
        if (m_tready) begin
          void'(exp_q.pop_front());
          xfer_cyc.push_back(cyc);
        end
      end
    end
    acc = req_v & req_r;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) void'(pkt_q[i].pop_front());
    end
    cyc++;
  endtask

  task automatic addBursts(input int r, input int n);
    for (int k = 0; k < n * BB; k++) begin
      pkt_q[r].push_back({$urandom(), $urandom(), 16'($urandom())});
    end
  endtask

  // Burst-level reference: every requester holding whole bursts stays valid,
  // so grants simply rotate among requesters with bursts left, starting one
  // past the previous winner. Each grant costs one credit.
  function automatic void buildExpected();
    int    rem [NUM_REQ];
    int    ptr [NUM_REQ];
    int    r;
    bit    any;
    beat_t b;
    r = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rem[i] = pkt_q[i].size() / BB;
      ptr[i] = 0;
    end
    do begin
      any = 1'b0;
      for (int off = 1; off <= NUM_REQ && !any; off++) begin
        r = (model_last + off) % NUM_REQ;
        if (rem[r] > 0) any = 1'b1;
      end
      if (any) begin
        for (int k = 0; k < BB; k++) begin
          b.data = {48'h0, pkt_q[r][ptr[r] + k]};
          b.keep = 16'h03FF;
          b.last = (k == BB - 1);
          exp_q.push_back(b);
        end
        ptr[r]    += BB;
        rem[r]    -= 1;
        model_last = r;
        exp_credits--;
      end
    end while (any);
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      applyStimulus(1'b0);
      n++;
    end
    if (exp_q.size() != 0) begin
      checkOutput("drain_timeout", 128'(exp_q.size()), 128'd0);
      exp_q.delete();
    end
    applyStimulus(1'b0);
    applyStimulus(1'b0);
  endtask

  // Hard stop in case something wedges the stimulus flow.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    beat_t b;
    int    n;
    resetn        = 1'b0;
    req_v         = '0;
    req_data      = '0;
    m_tready      = 1'b1;
    credit_return = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_tvalid",  128'(m_tvalid), 128'd0);
    checkOutput("rst_tlast",   128'(m_tlast),  128'd0);
    checkOutput("rst_busy",    128'(busy),     128'd0);
    checkOutput("rst_req_r",   128'(req_r),    128'd0);
    checkOutput("rst_credits", 128'(credits),  128'(CREDITS));
    @(negedge clk);
    resetn = 1'b1;

    // A return while already full is ignored
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("credit_saturate", 128'(credits), 128'(CREDITS));

    // All requesters valid, ready always high: grants 0,1,2,3,0
    tready_mode = 0;
    addBursts(0, 2);
    for (int r = 1; r < NUM_REQ; r++) addBursts(r, 1);
    buildExpected();
    drain(100);
    checkOutput("credits_after_5", 128'(credits), 128'd507);

    // Random requester subsets with random backpressure
    for (int rnd = 0; rnd < 4; rnd++) begin
      int mask;
      tready_mode = 1;
      mask = $urandom_range(1, (1 << NUM_REQ) - 1);
      for (int r = 0; r < NUM_REQ; r++) begin
        if (mask[r]) addBursts(r, $urandom_range(1, 2));
      end
      buildExpected();
      drain(400);
      checkOutput("rand_credits", 128'(credits), 128'(exp_credits));
      checkOutput("rand_idle",    128'(busy),    128'd0);
    end

    // Short burst: two data beats, then padding after the stall timeout
    tready_mode = 0;
    xfer_cyc.delete();
    for (int k = 0; k < 2; k++) begin
      pkt_q[2].push_back({$urandom(), $urandom(), 16'($urandom())});
      b.data = {48'h0, pkt_q[2][k]};
      b.keep = 16'h03FF;
      b.last = 1'b0;
      exp_q.push_back(b);
    end
    for (int k = 0; k < 2; k++) begin
      b.data = '0;
      b.keep = 16'h0000;
      b.last = (k == 1);
      exp_q.push_back(b);
    end
    model_last = 2;
    exp_credits--;
    drain(100);
    if (xfer_cyc.size() >= 3)
      checkOutput("pad_gap", 128'(xfer_cyc[2] - xfer_cyc[1]), 128'(PAD_TIMEOUT + 1));
    else
      checkOutput("pad_beats_seen", 128'(xfer_cyc.size()), 128'd4);
    checkOutput("pad_credits", 128'(credits), 128'(exp_credits));

    // Ready toggling every cycle during bursts
    tready_mode = 2;
    addBursts(1, 1);
    addBursts(3, 1);
    buildExpected();
    drain(200);
    checkOutput("toggle_credits", 128'(credits), 128'(exp_credits));

    // Reset on the second beat of a burst
    tready_mode = 0;
    for (int r = 0; r < NUM_REQ; r++) addBursts(r, 1);
    buildExpected();
    xfer_cyc.delete();
    n = 0;
    while (xfer_cyc.size() < 2 && n < 50) begin
      applyStimulus(1'b0);
      n++;
    end
    checkOutput("reached_beat2", 128'(xfer_cyc.size()), 128'd2);
    resetn = 1'b0;
    #1;
    checkOutput("midrst_tvalid",  128'(m_tvalid), 128'd0);
    checkOutput("midrst_tlast",   128'(m_tlast),  128'd0);
    checkOutput("midrst_tdata",   m_tdata,        128'd0);
    checkOutput("midrst_tkeep",   128'(m_tkeep),  128'd0);
    checkOutput("midrst_busy",    128'(busy),     128'd0);
    checkOutput("midrst_req_r",   128'(req_r),    128'd0);
    for (int r = 0; r < NUM_REQ; r++) pkt_q[r].delete();
    exp_q.delete();
    req_v       = '0;
    model_last  = NUM_REQ - 1;
    exp_credits = CREDITS;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checkOutput("postrst_credits", 128'(credits), 128'(CREDITS));
    for (int r = 0; r < NUM_REQ; r++) addBursts(r, 1);
    buildExpected();
    drain(100);
    checkOutput("postrst_credits4", 128'(credits), 128'd508);

    // Run credits down to 10, then grant with a coincident return
    addBursts(1, exp_credits - 10);
    buildExpected();
    drain(4000);
    checkOutput("credits_at_10", 128'(credits), 128'd10);
    addBursts(2, 1);
    buildExpected();
    exp_credits++;
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("coincident_return", 128'(credits), 128'd10);
    checkOutput("grant_with_return", 128'(busy),    128'd1);
    drain(100);
    checkOutput("credits_still_10", 128'(credits), 128'd10);

    // Drain to zero: requests blocked until one credit comes back
    addBursts(3, 10);
    buildExpected();
    drain(200);
    checkOutput("credits_zero", 128'(credits), 128'd0);
    addBursts(1, 1);
    repeat (20) applyStimulus(1'b0);
    checkOutput("no_grant_at_zero",  128'(busy),              128'd0);
    checkOutput("no_accept_at_zero", 128'(pkt_q[1].size()),   128'(BB));
    buildExpected();
    exp_credits++;
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("credit_back",       128'(credits), 128'd1);
    checkOutput("not_yet_granted",   128'(busy),    128'd0);
    applyStimulus(1'b0);
    checkOutput("grant_after_return", 128'(busy),    128'd1);
    checkOutput("credit_spent",       128'(credits), 128'd0);
    drain(100);
    checkOutput("final_credits", 128'(credits), 128'(exp_credits));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
